// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types for the MAC sequencer: FSM state encoding and its width.
package mac_seq_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/en_delay_line.sv
// DEPTH-deep 1-bit shift register with synchronous clear; aligns read enables with returning data.
// empty_next_o reports that the line will hold no enables after the coming edge.
module en_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic en_o,
    output logic empty_next_o
);

    logic [DEPTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = (sr_q << 1) | DEPTH'(en_i);
        if (clr_i) begin
            sr_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign en_o         = sr_q[DEPTH-1];
    assign empty_next_o = ~|sr_d;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for one MAC: clears the accumulator, streams Len operand-pair reads, aligns MAC
// write-enables with read data, then holds the result valid until the consumer takes it.
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 9,
    parameter int RD_LAT     = 1
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  Start_SI,
    input  logic [LEN_WIDTH-1:0]  Len_DI,
    input  logic [ADDR_WIDTH-1:0] BaseA_DI,
    input  logic [ADDR_WIDTH-1:0] BaseB_DI,
    input  logic                  Abort_SI,
    output logic                  Busy_SO,
    output logic                  RdEn_SO,
    output logic [ADDR_WIDTH-1:0] AddrA_DO,
    output logic [ADDR_WIDTH-1:0] AddrB_DO,
    output logic                  MacClr_SO,
    output logic                  MacWrEn_SO,
    output logic                  ResValid_SO,
    input  logic                  ResReady_SI
);

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
    logic                  pipe_en, pipe_empty_next, flush;

    en_delay_line #(
        .DEPTH (RD_LAT)
    ) u_wr_pipe (
        .clk_i        (Clk_CI),
        .rst_ni       (Rst_RBI),
        .clr_i        (flush),
        .en_i         (RdEn_SO),
        .en_o         (pipe_en),
        .empty_next_o (pipe_empty_next)
    );

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        flush    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start_SI) begin
                    state_d  = CLEAR;
                    rem_d    = Len_DI;
                    addr_a_d = BaseA_DI;
                    addr_b_d = BaseB_DI;
                end
            end
            CLEAR: state_d = (rem_q == '0) ? DONE : FETCH;
            FETCH: begin
                addr_a_d = addr_a_q + ADDR_WIDTH'(1);
                addr_b_d = addr_b_q + ADDR_WIDTH'(1);
                rem_d    = rem_q - LEN_WIDTH'(1);
                if (rem_q == LEN_WIDTH'(1)) begin
                    state_d = DRAIN;
                end
            end
            // Leave once the final write-enable is on the pipe output this cycle.
            DRAIN: if (pipe_empty_next) state_d = DONE;
            DONE:  if (ResReady_SI) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (Abort_SI && (state_q != IDLE)) begin
            state_d = IDLE;
            flush   = 1'b1;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
        end
    end

    always_comb begin
        Busy_SO     = (state_q != IDLE);
        RdEn_SO     = (state_q == FETCH);
        MacClr_SO   = (state_q == CLEAR);
        MacWrEn_SO  = (state_q == CLEAR) | pipe_en;
        ResValid_SO = (state_q == DONE);
        AddrA_DO    = addr_a_q;
        AddrB_DO    = addr_b_q;
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench: two sequencers (RD_LAT 1 and 3) driving ROM + MAC models, cycle-level checks.
module tb_mac_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, rready, sel;
    logic [8:0] len;
    logic [7:0] base_a, base_b;

    logic       busy1, rden1, clr1, we1, val1;
    logic [7:0] aa1, ab1;
    logic       busy3, rden3, clr3, we3, val3;
    logic [7:0] aa3, ab3;
    logic       start1, start3;

    logic       busy, rden, mclr, mwe, val;
    logic [7:0] aa, ab;

    logic signed [31:0] rom_a [0:255];
    logic signed [31:0] rom_b [0:255];
    logic signed [31:0] pa1, pb1, acc1, acc3, acc;
    logic signed [31:0] pa3 [3];
    logic signed [31:0] pb3 [3];

    int n_cmp = 0;
    int n_bad = 0;

    int wr_cnt, rd_cnt, clr_cnt, val_cnt, first_wr, last_wr, first_val;
    logic [7:0]         alog [4];
    logic [7:0]         blog [4];
    logic [31:0]        busy_log;
    logic signed [31:0] acc_first;

    always #5 clk = ~clk;

    assign start1 = start & ~sel;
    assign start3 = start & sel;

    mac_seq_ctrl #(.ADDR_WIDTH(8), .LEN_WIDTH(9), .RD_LAT(1)) dut1 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start1), .Len_DI(len),
        .BaseA_DI(base_a), .BaseB_DI(base_b), .Abort_SI(abort), .Busy_SO(busy1),
        .RdEn_SO(rden1), .AddrA_DO(aa1), .AddrB_DO(ab1), .MacClr_SO(clr1),
        .MacWrEn_SO(we1), .ResValid_SO(val1), .ResReady_SI(rready)
    );

    mac_seq_ctrl #(.ADDR_WIDTH(8), .LEN_WIDTH(9), .RD_LAT(3)) dut3 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start3), .Len_DI(len),
        .BaseA_DI(base_a), .BaseB_DI(base_b), .Abort_SI(abort), .Busy_SO(busy3),
        .RdEn_SO(rden3), .AddrA_DO(aa3), .AddrB_DO(ab3), .MacClr_SO(clr3),
        .MacWrEn_SO(we3), .ResValid_SO(val3), .ResReady_SI(rready)
    );

    // ROM read pipes and MAC accumulators
    always @(posedge clk) begin
        pa1    <= rom_a[aa1];
        pb1    <= rom_b[ab1];
        pa3[0] <= rom_a[aa3];
        pa3[1] <= pa3[0];
        pa3[2] <= pa3[1];
        pb3[0] <= rom_b[ab3];
        pb3[1] <= pb3[0];
        pb3[2] <= pb3[1];
        if (we1) acc1 <= clr1 ? 32'sd0 : acc1 + pa1 * pb1;
        if (we3) acc3 <= clr3 ? 32'sd0 : acc3 + pa3[2] * pb3[2];
    end

    always_comb begin
        busy = sel ? busy3 : busy1;
        rden = sel ? rden3 : rden1;
        mclr = sel ? clr3  : clr1;
        mwe  = sel ? we3   : we1;
        val  = sel ? val3  : val1;
        aa   = sel ? aa3   : aa1;
        ab   = sel ? ab3   : ab1;
        acc  = sel ? acc3  : acc1;
    end

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called just before an edge: that edge accepts the start (edge 0).
    task automatic go(input logic s, input int l, input int ba, input int bb);
        sel    = s;
        len    = 9'(l);
        base_a = 8'(ba);
        base_b = 8'(bb);
        start  = 1'b1;
        @(posedge clk);
    endtask

    // Samples cycles 1..ncyc after the start edge; scrambles inputs after cycle 1.
    task automatic run(input int ncyc, input int abort_at, input int start_at);
        wr_cnt = 0; rd_cnt = 0; clr_cnt = 0; val_cnt = 0;
        first_wr = 0; last_wr = 0; first_val = 0; busy_log = '0; acc_first = '0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (mwe && !mclr) begin
                wr_cnt++;
                if (first_wr == 0) first_wr = c;
                last_wr = c;
            end
            if (rden) begin
                if (rd_cnt < 4) begin
                    alog[rd_cnt] = aa;
                    blog[rd_cnt] = ab;
                end
                rd_cnt++;
            end
            if (mclr) clr_cnt++;
            if (val) begin
                val_cnt++;
                if (first_val == 0) begin
                    first_val = c;
                    acc_first = acc;
                end
            end
            if (c < 32) busy_log[c] = busy;
            abort = (c == abort_at);
            start = (c == start_at);
            if (c == 1) begin
                len    = 9'h1ff;
                base_a = 8'h55;
                base_b = 8'haa;
            end
        end
    endtask

    task automatic handshake(input string tag, input logic with_start);
        rready = 1'b1;
        start  = with_start;
        @(negedge clk);
        check(tag, busy, 0);
        rready = 1'b0;
        start  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; rready = 1'b0; sel = 1'b0;
        len = '0; base_a = '0; base_b = '0;
        for (int i = 0; i < 256; i++) begin
            rom_a[i] = 0;
            rom_b[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            rom_a[i] = i + 1;
            rom_b[i] = i + 5;
        end
        rom_a[10] = -2; rom_a[11] = 3; rom_a[12] = -4;
        rom_b[20] = 5;  rom_b[21] = 5; rom_b[22] = 5;

        repeat (3) @(negedge clk);
        check("rst_out_lat1", {busy1, rden1, aa1, ab1, clr1, we1, val1}, 0);
        check("rst_out_lat3", {busy3, rden3, aa3, ab3, clr3, we3, val3}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Len=4 dot product, result held 6 cycles, Start in DONE ignored
        go(1'b0, 4, 0, 0);
        run(12, 0, 9);
        check("t1_wr_cnt", wr_cnt, 4);
        check("t1_first_wr", first_wr, 3);
        check("t1_last_wr", last_wr, 6);
        check("t1_rd_cnt", rd_cnt, 4);
        check("t1_clr_cnt", clr_cnt, 1);
        check("t1_first_val", first_val, 7);
        check("t1_val_cnt", val_cnt, 6);
        check("t1_res_first", acc_first, 70);
        check("t1_res_held", acc, 70);
        handshake("t1_hs_start_ignored", 1'b1);

        // Len=0: clear only, result 0 at cycle 2
        go(1'b0, 0, 0, 0);
        run(4, 0, 0);
        check("t2_first_val", first_val, 2);
        check("t2_wr_cnt", wr_cnt, 0);
        check("t2_rd_cnt", rd_cnt, 0);
        check("t2_clr_cnt", clr_cnt, 1);
        check("t2_res", acc_first, 0);
        handshake("t2_hs", 1'b0);

        // RD_LAT=3 signed operands, run twice back to back
        for (int r = 0; r < 2; r++) begin
            go(1'b1, 3, 10, 20);
            run(10, 0, 0);
            check("t3_first_wr", first_wr, 5);
            check("t3_last_wr", last_wr, 7);
            check("t3_wr_cnt", wr_cnt, 3);
            check("t3_first_val", first_val, 8);
            check("t3_res", acc_first, -15);
            handshake("t3_hs", 1'b0);
        end

        // Address wrap
        go(1'b0, 4, 254, 0);
        run(8, 0, 0);
        check("t4_addr_a", {alog[0], alog[1], alog[2], alog[3]}, {8'd254, 8'd255, 8'd0, 8'd1});
        check("t4_addr_b", {blog[0], blog[1], blog[2], blog[3]}, {8'd0, 8'd1, 8'd2, 8'd3});
        handshake("t4_hs", 1'b0);

        // Abort at k=2 (cycle 4), Start pulsed while busy in cycle 2
        go(1'b0, 4, 0, 0);
        run(8, 4, 2);
        check("t5_wr_cnt", wr_cnt, 2);
        check("t5_rd_cnt", rd_cnt, 3);
        check("t5_busy_after", busy_log[8:5], 0);
        check("t5_no_valid", val_cnt, 0);
        check("t5_clr_cnt", clr_cnt, 1);

        // Reset mid-FETCH, then a normal run
        go(1'b0, 4, 0, 0);
        run(3, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_out", {busy1, rden1, aa1, ab1, clr1, we1, val1}, 0);
        rst_n = 1'b1;
        run(4, 0, 0);
        check("t6_quiet_wr", wr_cnt, 0);
        check("t6_quiet_busy", busy_log[4:1], 0);
        go(1'b0, 4, 0, 0);
        run(8, 0, 0);
        check("t6_first_val", first_val, 7);
        check("t6_res", acc_first, 70);
        handshake("t6_hs", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
